// File: rtl/adder_stream_arbiter.sv
// Packet-level round-robin arbiter feeding one adder datapath from two AXI4-Stream sources.
// The winner's constant is registered during a one-cycle SETUP so the adder latches it before beat 1.
module adder_stream_arbiter #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_ADDER_BIT_WIDTH  = 32,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              enable,
    input  logic [C_ADDER_BIT_WIDTH-1:0]      ctrl_constant0,
    input  logic [C_ADDER_BIT_WIDTH-1:0]      ctrl_constant1,
    input  logic                              s0_axis_tvalid,
    output logic                              s0_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]     s0_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s0_axis_tkeep,
    input  logic                              s0_axis_tlast,
    input  logic                              s1_axis_tvalid,
    output logic                              s1_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]     s1_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s1_axis_tkeep,
    input  logic                              s1_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tid,
    output logic [C_ADDER_BIT_WIDTH-1:0]      adder_constant,
    output logic                              busy,
    output logic [C_CNT_WIDTH-1:0]            pkt_cnt0,
    output logic [C_CNT_WIDTH-1:0]            pkt_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    state_t                          state_reg, state_next;
    logic                            grant_reg, grant_next;
    logic                            last_served_reg, last_served_next;
    logic [C_ADDER_BIT_WIDTH-1:0]    adder_constant_reg, adder_constant_next;
    logic [C_CNT_WIDTH-1:0]          pkt_cnt0_reg, pkt_cnt0_next;
    logic [C_CNT_WIDTH-1:0]          pkt_cnt1_reg, pkt_cnt1_next;

    logic [1:0]                      src_tvalid;
    logic [1:0]                      src_tready;
    logic                            xfer_hs;

    assign src_tvalid = {s1_axis_tvalid, s0_axis_tvalid};

    // Only the granted source sees the downstream ready, and only while transferring.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_tready
            assign src_tready[gi] = (state_reg == ST_XFER) && (grant_reg == 1'(gi)) && m_axis_tready;
        end
    endgenerate

    assign s0_axis_tready = src_tready[0];
    assign s1_axis_tready = src_tready[1];

    assign m_axis_tvalid  = (state_reg == ST_XFER) && (grant_reg ? s1_axis_tvalid : s0_axis_tvalid);
    assign m_axis_tdata   = grant_reg ? s1_axis_tdata : s0_axis_tdata;
    assign m_axis_tkeep   = grant_reg ? s1_axis_tkeep : s0_axis_tkeep;
    assign m_axis_tlast   = grant_reg ? s1_axis_tlast : s0_axis_tlast;
    assign m_axis_tid     = grant_reg;
    assign xfer_hs        = m_axis_tvalid && m_axis_tready;

    assign adder_constant = adder_constant_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign pkt_cnt0       = pkt_cnt0_reg;
    assign pkt_cnt1       = pkt_cnt1_reg;

    always_comb begin
        state_next          = state_reg;
        grant_next          = grant_reg;
        last_served_next    = last_served_reg;
        adder_constant_next = adder_constant_reg;
        pkt_cnt0_next       = pkt_cnt0_reg;
        pkt_cnt1_next       = pkt_cnt1_reg;
        case (state_reg)
            ST_IDLE: begin
                if (enable && (src_tvalid != 2'b00)) begin
                    // With both pending, the source that was not served last wins.
                    if (src_tvalid == 2'b11) begin
                        grant_next = ~last_served_reg;
                    end else begin
                        grant_next = src_tvalid[1];
                    end
                    adder_constant_next = grant_next ? ctrl_constant1 : ctrl_constant0;
                    state_next          = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_XFER;
            end
            ST_XFER: begin
                if (xfer_hs && m_axis_tlast) begin
                    if (grant_reg) begin
                        pkt_cnt1_next = pkt_cnt1_reg + C_CNT_WIDTH'(1);
                    end else begin
                        pkt_cnt0_next = pkt_cnt0_reg + C_CNT_WIDTH'(1);
                    end
                    last_served_next = grant_reg;
                    state_next       = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg          <= ST_IDLE;
            grant_reg          <= 1'b0;
            last_served_reg    <= 1'b1;
            adder_constant_reg <= '0;
            pkt_cnt0_reg       <= '0;
            pkt_cnt1_reg       <= '0;
        end else begin
            state_reg          <= state_next;
            grant_reg          <= grant_next;
            last_served_reg    <= last_served_next;
            adder_constant_reg <= adder_constant_next;
            pkt_cnt0_reg       <= pkt_cnt0_next;
            pkt_cnt1_reg       <= pkt_cnt1_next;
        end
    end

endmodule

// File: tb/tb_adder_stream_arbiter.sv
// Scoreboard bench for adder_stream_arbiter: per-source expected-beat queues are filled by the
// source drivers and drained by a monitor sampling just before each rising edge.
module tb_adder_stream_arbiter;

    localparam int W  = 512;
    localparam int B  = 32;
    localparam int C  = 32;
    localparam int KW = W / 8;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [KW-1:0] keep;
        logic          last;
        logic [B-1:0]  cst;
    } beat_t;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          enable = 1'b0;
    logic [B-1:0]  ctrl_constant0 = '0;
    logic [B-1:0]  ctrl_constant1 = '0;
    logic          s_tvalid [2];
    logic          s_tready [2];
    logic [W-1:0]  s_tdata  [2];
    logic [KW-1:0] s_tkeep  [2];
    logic          s_tlast  [2];
    logic          m_tvalid;
    logic          m_ready = 1'b1;
    logic [W-1:0]  m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tid;
    logic [B-1:0]  adder_constant;
    logic          busy;
    logic [C-1:0]  pkt_cnt0, pkt_cnt1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int beats_seen [2] = '{0, 0};
    int cur_beats = 0;
    beat_t exp_q0 [$];
    beat_t exp_q1 [$];
    int order_q [$];
    int rise_cyc [$];
    int tlast_cyc [$];
    logic [B-1:0] first_cst_q [$];
    logic prev_valid = 1'b0;
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic done0, done1;

    adder_stream_arbiter #(
        .C_AXIS_TDATA_WIDTH(W),
        .C_ADDER_BIT_WIDTH(B),
        .C_CNT_WIDTH(C)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .enable(enable),
        .ctrl_constant0(ctrl_constant0),
        .ctrl_constant1(ctrl_constant1),
        .s0_axis_tvalid(s_tvalid[0]),
        .s0_axis_tready(s_tready[0]),
        .s0_axis_tdata(s_tdata[0]),
        .s0_axis_tkeep(s_tkeep[0]),
        .s0_axis_tlast(s_tlast[0]),
        .s1_axis_tvalid(s_tvalid[1]),
        .s1_axis_tready(s_tready[1]),
        .s1_axis_tdata(s_tdata[1]),
        .s1_axis_tkeep(s_tkeep[1]),
        .s1_axis_tlast(s_tlast[1]),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_ready),
        .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep),
        .m_axis_tlast(m_tlast),
        .m_axis_tid(m_tid),
        .adder_constant(adder_constant),
        .busy(busy),
        .pkt_cnt0(pkt_cnt0),
        .pkt_cnt1(pkt_cnt1)
    );

    always #5 aclk = ~aclk;

    function automatic logic [W-1:0] lanes(input logic [31:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    // Monitor: samples 1 ns before each rising edge.
    always begin : mon
        beat_t e;
        logic got;
        @(negedge aclk);
        #4;
        cyc++;
        if (areset) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
            cur_beats  = 0;
        end else begin
            if (m_tvalid && !prev_valid) rise_cyc.push_back(cyc);
            prev_valid = m_tvalid;
            if (m_tvalid && prev_stall) begin
                total++;
                if (m_tdata !== prev_data) begin
                    bad++;
                    $display("FAIL stall_hold: tdata=%h required=%h", m_tdata[31:0], prev_data[31:0]);
                end
            end
            prev_stall = m_tvalid && !m_ready;
            prev_data  = m_tdata;
            if (m_tvalid && m_ready) begin
                got = 1'b0;
                e   = '0;
                if (m_tid == 1'b0 && exp_q0.size() > 0) begin
                    e = exp_q0.pop_front();
                    got = 1'b1;
                end else if (m_tid == 1'b1 && exp_q1.size() > 0) begin
                    e = exp_q1.pop_front();
                    got = 1'b1;
                end
                total++;
                if (!got) begin
                    bad++;
                    $display("FAIL unexpected_beat: tid=%0d tdata=%h, required no beat", m_tid, m_tdata[31:0]);
                end else begin
                    total += 3;
                    if (m_tdata !== e.data) begin
                        bad++;
                        $display("FAIL beat_data: tid=%0d tdata=%h required=%h", m_tid, m_tdata[31:0], e.data[31:0]);
                    end
                    if ({m_tkeep, m_tlast} !== {e.keep, e.last}) begin
                        bad++;
                        $display("FAIL beat_keep_last: keep=%h last=%b required keep=%h last=%b",
                                 m_tkeep, m_tlast, e.keep, e.last);
                    end
                    if (adder_constant !== e.cst) begin
                        bad++;
                        $display("FAIL beat_constant: adder_constant=%0d required=%0d", adder_constant, e.cst);
                    end
                end
                beats_seen[m_tid]++;
                cur_beats++;
                if (cur_beats == 1) first_cst_q.push_back(adder_constant);
                if (m_tlast) begin
                    order_q.push_back(int'(m_tid));
                    tlast_cyc.push_back(cyc);
                    $display("packet: src=%0d beats=%0d constant=%0d cycle=%0d", m_tid, cur_beats, adder_constant, cyc);
                    cur_beats = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    // Drives one packet from source src; called and returns on a falling edge.
    task automatic send_pkt(input int src, input int n, input logic [31:0] base, input logic [B-1:0] cst);
        for (int b = 0; b < n; b++) begin
            beat_t e;
            logic hs;
            int wc;
            s_tdata[src]  = lanes(base + 32'(b));
            s_tkeep[src]  = (b == n - 1) ? {$urandom, $urandom} : {KW{1'b1}};
            s_tlast[src]  = (b == n - 1);
            s_tvalid[src] = 1'b1;
            e.data = s_tdata[src];
            e.keep = s_tkeep[src];
            e.last = s_tlast[src];
            e.cst  = cst;
            if (src == 0) exp_q0.push_back(e);
            else          exp_q1.push_back(e);
            hs = 1'b0;
            wc = 0;
            while (!hs && wc < 300) begin
                #4;
                hs = s_tready[src];
                @(negedge aclk);
                wc++;
            end
            total++;
            if (!hs) begin
                bad++;
                $display("FAIL handshake_timeout: src=%0d beat=%0d tready=0 after %0d cycles, required 1", src, b, wc);
            end
        end
        s_tvalid[src] = 1'b0;
        s_tlast[src]  = 1'b0;
    endtask

    task automatic do_reset;
        areset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
        @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            s_tvalid[i] = 1'b0;
            s_tdata[i]  = '0;
            s_tkeep[i]  = '0;
            s_tlast[i]  = 1'b0;
        end
        areset = 1'b1;
        @(negedge aclk);
        #2;
        total += 2;
        if ({m_tvalid, busy, s_tready[0], s_tready[1]} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: tvalid,busy,tready0,tready1=%b required 0000",
                     {m_tvalid, busy, s_tready[0], s_tready[1]});
        end
        if ({adder_constant, pkt_cnt0, pkt_cnt1} !== '0) begin
            bad++;
            $display("FAIL reset_regs: constant=%0d cnt0=%0d cnt1=%0d required 0 0 0", adder_constant, pkt_cnt0, pkt_cnt1);
        end
        @(negedge aclk);
        areset = 1'b0;
        #4;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_busy: busy=%b required 0", busy);
        end
        @(negedge aclk);
    endtask

    task automatic test_single;
        enable = 1'b1;
        ctrl_constant0 = 32'd5;
        fork
            send_pkt(0, 4, 32'd10, 32'd5);
            begin
                #4;
                total++;
                if ({m_tvalid, busy} !== 2'b00) begin
                    bad++;
                    $display("FAIL single_idle: tvalid,busy=%b required 00", {m_tvalid, busy});
                end
                @(negedge aclk);
                #4;
                total++;
                if ({busy, m_tvalid, adder_constant} !== {1'b1, 1'b0, 32'd5}) begin
                    bad++;
                    $display("FAIL single_setup: busy=%b tvalid=%b constant=%0d required 1 0 5", busy, m_tvalid, adder_constant);
                end
                ctrl_constant0 = 32'd99;
                @(negedge aclk);
                #4;
                total++;
                if ({m_tvalid, m_tid} !== 2'b10) begin
                    bad++;
                    $display("FAIL single_first_beat: tvalid=%b tid=%b required 1 0", m_tvalid, m_tid);
                end
            end
        join
        #4;
        total++;
        if (pkt_cnt0 !== 32'd1) begin
            bad++;
            $display("FAIL single_cnt0: pkt_cnt0=%0d required 1", pkt_cnt0);
        end
        @(negedge aclk);
    endtask

    task automatic test_round_robin;
        int exp_order [4];
        logic [B-1:0] exp_cst [4];
        exp_order = '{0, 1, 0, 1};
        exp_cst   = '{32'd1, 32'd2, 32'd1, 32'd2};
        do_reset();
        ctrl_constant0 = 32'd1;
        ctrl_constant1 = 32'd2;
        enable = 1'b1;
        order_q.delete();
        rise_cyc.delete();
        tlast_cyc.delete();
        first_cst_q.delete();
        fork
            begin
                send_pkt(0, 3, 32'd100, 32'd1);
                send_pkt(0, 3, 32'd200, 32'd1);
            end
            begin
                send_pkt(1, 3, 32'd300, 32'd2);
                send_pkt(1, 3, 32'd400, 32'd2);
            end
        join
        #4;
        total++;
        if (order_q.size() != 4 || first_cst_q.size() != 4 || rise_cyc.size() != 4 || tlast_cyc.size() != 4) begin
            bad++;
            $display("FAIL rr_packets: packets=%0d required 4", order_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total += 2;
                if (order_q[i] != exp_order[i]) begin
                    bad++;
                    $display("FAIL rr_order: packet %0d src=%0d required %0d", i, order_q[i], exp_order[i]);
                end
                if (first_cst_q[i] !== exp_cst[i]) begin
                    bad++;
                    $display("FAIL rr_constant: packet %0d constant=%0d required %0d", i, first_cst_q[i], exp_cst[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                total++;
                if (rise_cyc[i] - tlast_cyc[i-1] != 3) begin
                    bad++;
                    $display("FAIL rr_gap: packet %0d gap=%0d cycles required 3", i, rise_cyc[i] - tlast_cyc[i-1]);
                end
            end
        end
        total++;
        if ({pkt_cnt0, pkt_cnt1} !== {32'd2, 32'd2}) begin
            bad++;
            $display("FAIL rr_counts: cnt0=%0d cnt1=%0d required 2 2", pkt_cnt0, pkt_cnt1);
        end
        @(negedge aclk);
    endtask

    task automatic test_backpressure;
        int base1;
        base1 = beats_seen[1];
        ctrl_constant1 = 32'd7;
        done0 = 1'b0;
        done1 = 1'b0;
        fork
            begin
                send_pkt(1, 5, 32'd500, 32'd7);
                done1 = 1'b1;
            end
            begin
                repeat (3) @(negedge aclk);
                send_pkt(0, 1, 32'd600, ctrl_constant0);
                done0 = 1'b1;
            end
            begin
                int k;
                k = 0;
                while (!(done0 && done1) && k < 200) begin
                    m_ready = (k % 2 == 0);
                    #4;
                    if (m_tvalid && m_tid == 1'b1) begin
                        total += 2;
                        if (s_tready[1] !== m_ready) begin
                            bad++;
                            $display("FAIL bp_tready1: s1_tready=%b required %b", s_tready[1], m_ready);
                        end
                        if (s_tready[0] !== 1'b0) begin
                            bad++;
                            $display("FAIL bp_tready0: s0_tready=%b required 0", s_tready[0]);
                        end
                    end
                    @(negedge aclk);
                    k++;
                end
                m_ready = 1'b1;
            end
        join
        #4;
        total += 2;
        if (beats_seen[1] - base1 != 5 || exp_q1.size() != 0) begin
            bad++;
            $display("FAIL bp_beats: s1 beats=%0d pending=%0d required 5 0", beats_seen[1] - base1, exp_q1.size());
        end
        if (order_q.size() < 2 || order_q[order_q.size()-2] != 1 || order_q[order_q.size()-1] != 0) begin
            bad++;
            $display("FAIL bp_order: last packets not s1 then s0 (count=%0d), required 1 then 0", order_q.size());
        end
        @(negedge aclk);
    endtask

    task automatic test_enable;
        logic [C-1:0] base;
        int bseen;
        base  = pkt_cnt0;
        bseen = beats_seen[0];
        ctrl_constant0 = 32'd3;
        enable = 1'b1;
        fork
            begin
                send_pkt(0, 4, 32'd700, 32'd3);
                send_pkt(0, 2, 32'd800, 32'd3);
            end
            begin
                int k;
                k = 0;
                while (beats_seen[0] == bseen && k < 100) begin
                    @(negedge aclk);
                    k++;
                end
                enable = 1'b0;
                k = 0;
                while (pkt_cnt0 != base + 1 && k < 100) begin
                    @(negedge aclk);
                    k++;
                end
                total++;
                if (pkt_cnt0 !== base + 1) begin
                    bad++;
                    $display("FAIL en_complete: pkt_cnt0=%0d required %0d", pkt_cnt0, base + 1);
                end
                repeat (5) begin
                    #4;
                    total++;
                    if ({busy, m_tvalid} !== 2'b00) begin
                        bad++;
                        $display("FAIL en_hold: busy=%b tvalid=%b with enable low, required 0 0", busy, m_tvalid);
                    end
                    @(negedge aclk);
                end
                enable = 1'b1;
            end
        join
        #4;
        total += 2;
        if (pkt_cnt0 !== base + 2) begin
            bad++;
            $display("FAIL en_resume: pkt_cnt0=%0d required %0d", pkt_cnt0, base + 2);
        end
        if (order_q[order_q.size()-1] != 0) begin
            bad++;
            $display("FAIL en_regrant: last src=%0d required 0", order_q[order_q.size()-1]);
        end
        @(negedge aclk);
    endtask

    task automatic test_wrap;
        force dut.pkt_cnt1_reg = {C{1'b1}};
        @(negedge aclk);
        release dut.pkt_cnt1_reg;
        #4;
        total++;
        if (pkt_cnt1 !== {C{1'b1}}) begin
            bad++;
            $display("FAIL wrap_preload: pkt_cnt1=%h required ffffffff", pkt_cnt1);
        end
        @(negedge aclk);
        send_pkt(1, 2, 32'd900, ctrl_constant1);
        #4;
        total++;
        if (pkt_cnt1 !== '0) begin
            bad++;
            $display("FAIL wrap_cnt1: pkt_cnt1=%h required 0", pkt_cnt1);
        end
        @(negedge aclk);
    endtask

    task automatic test_reset_mid_packet;
        beat_t e;
        logic hs;
        int wc;
        enable = 1'b1;
        ctrl_constant0 = 32'd4;
        s_tdata[0]  = lanes(32'd1000);
        s_tkeep[0]  = {KW{1'b1}};
        s_tlast[0]  = 1'b0;
        s_tvalid[0] = 1'b1;
        e.data = s_tdata[0];
        e.keep = s_tkeep[0];
        e.last = 1'b0;
        e.cst  = 32'd4;
        exp_q0.push_back(e);
        hs = 1'b0;
        wc = 0;
        while (!hs && wc < 50) begin
            #4;
            hs = s_tready[0];
            @(negedge aclk);
            wc++;
        end
        total++;
        if (!hs) begin
            bad++;
            $display("FAIL rst_first_beat: tready=0 after %0d cycles, required 1", wc);
        end
        s_tdata[0] = lanes(32'd1001);
        #2;
        areset = 1'b1;
        #1;
        total += 2;
        if ({m_tvalid, busy, s_tready[0], s_tready[1]} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_mid_ctrl: tvalid,busy,tready0,tready1=%b required 0000",
                     {m_tvalid, busy, s_tready[0], s_tready[1]});
        end
        if ({adder_constant, pkt_cnt0, pkt_cnt1} !== '0) begin
            bad++;
            $display("FAIL rst_mid_regs: constant=%0d cnt0=%0d cnt1=%0d required 0 0 0", adder_constant, pkt_cnt0, pkt_cnt1);
        end
        @(negedge aclk);
        do_reset();
        send_pkt(1, 2, 32'd1100, ctrl_constant1);
        fork
            send_pkt(0, 1, 32'd1200, ctrl_constant0);
            send_pkt(1, 1, 32'd1300, ctrl_constant1);
        join
        #4;
        total += 2;
        if (order_q.size() < 3 || order_q[order_q.size()-3] != 1) begin
            bad++;
            $display("FAIL rst_alone_grant: src after reset not 1 (packets=%0d), required 1", order_q.size());
        end
        if (order_q.size() < 2 || order_q[order_q.size()-2] != 0 || order_q[order_q.size()-1] != 1) begin
            bad++;
            $display("FAIL rst_priority: both-valid order not 0 then 1 (packets=%0d), required 0 then 1", order_q.size());
        end
        @(negedge aclk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_enable();
        test_wrap();
        test_reset_mid_packet();
        total++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            bad++;
            $display("FAIL leftover_beats: q0=%0d q1=%0d required 0 0", exp_q0.size(), exp_q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_stream_arbiter.md
Name: adder_stream_arbiter

Overview:
- Shares one example-adder datapath between two AXI4-Stream producers.
- Arbitrates whole packets, bounded by tlast, round-robin.
- Drives the adder's constant input with the winning source's constant one cycle before the first beat, which covers the adder's internal constant register.
- Sits between the two read-side stream sources and the adder's s_axis port. Reports a per-source packet count.

Parameters:
- C_AXIS_TDATA_WIDTH, 512, data width of all streams (multiple of 8 and of C_ADDER_BIT_WIDTH).
- C_ADDER_BIT_WIDTH, 32, width of each constant and of adder_constant.
- C_CNT_WIDTH, 32, width of the packet counters.

Ports:
- aclk  in  1  single clock, rising edge.
- areset  in  1  asynchronous, active-high reset.
- enable  in  1  when high, new packets may be granted; an in-flight packet always completes.
- ctrl_constant0  in  C_ADDER_BIT_WIDTH  constant applied to source-0 packets.
- ctrl_constant1  in  C_ADDER_BIT_WIDTH  constant applied to source-1 packets.
- s0_axis_tvalid/tready/tdata/tkeep/tlast  in/out/in/in/in  1/1/W/W/8/1  source-0 stream.
- s1_axis_tvalid/tready/tdata/tkeep/tlast  in/out/in/in/in  1/1/W/W/8/1  source-1 stream.
- m_axis_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  1/1/W/W/8/1  to the adder's s_axis.
- m_axis_tid  out  1  source index of the current beat.
- adder_constant  out  C_ADDER_BIT_WIDTH  to the adder's ctrl_constant; registered.
- busy  out  1  high in SETUP or XFER.
- pkt_cnt0, pkt_cnt1  out  C_CNT_WIDTH  count of completed packets per source.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, grant=0, last_served=1 (source 0 has first priority).
  - adder_constant=0, pkt_cnt0=pkt_cnt1=0, busy=0.
  - m_axis_tvalid=0, s0/s1_axis_tready=0.
- FSM states: IDLE, SETUP, XFER.
- IDLE:
  - All treadys=0, m_axis_tvalid=0.
  - If enable and any sK_axis_tvalid: grant=K, register adder_constant<=ctrl_constantK, go to SETUP.
  - If both valid, K is the source not equal to last_served.
  - tvalid of a source not granted is held pending; no drop.
- SETUP:
  - Exactly one cycle; no transfer (treadys=0, m_axis_tvalid=0).
  - Exists so the adder's constant register captures adder_constant before beat 1.
  - Always goes to XFER.
- XFER (combinational pass-through, zero latency):
  - m_axis_tvalid/tdata/tkeep/tlast = s{grant} signals; s{grant}_axis_tready=m_axis_tready; the other tready=0; m_axis_tid=grant.
  - On handshake (m_axis_tvalid & m_axis_tready) with tlast=1: pkt_cnt{grant}+=1, last_served<=grant, go to IDLE.
- adder_constant holds its value from the grant until the next grant; it never changes in SETUP or XFER.
- Changes to ctrl_constantK during a packet do not affect that packet.
- enable deasserted during SETUP/XFER: the packet completes normally; IDLE then holds off further grants.
- Throughput: 2 idle cycles (IDLE, SETUP) between packets; within a packet, 1 beat/cycle when valid and ready are both high.
- Single-beat packet (tlast on beat 1): legal; same sequence.
- Counters: wrap modulo 2^C_CNT_WIDTH (all-ones +1 -> 0) with no flag.
- Simultaneous events:
  - A competing tvalid during SETUP/XFER is ignored until IDLE.
  - A source that re-asserts immediately after its own tlast loses to a waiting other source.
  - When alone it is regranted.
- Reset mid-packet: immediate return to IDLE. The packet is truncated with no tlast emitted; the source must be reset by the same areset.
- Backpressure: m_axis_tready low holds the beat. AXIS rule: tdata/tkeep/tlast are stable while tvalid is high and tready is low, inherited from the source.

Test Plan:
- Reset then s0 sends a 4-beat packet with constant0=5, tdata lanes=10, m_axis_tready=1 -> adder_constant=5 from the cycle after grant; tvalid rises at cycle 2 after s0 tvalid; 4 beats with tid=0, tlast on beat 4; pkt_cnt0=1.
- Both sources valid from reset, 3-beat packets each, constants 1 and 2 -> order s0,s1,s0,s1. adder_constant alternates 1,2,1,2. Each packet is preceded by exactly 2 non-transfer cycles. Final pkt_cnt0=pkt_cnt1=2.
- m_axis_tready toggled 1010 during a 5-beat s1 packet -> no beat lost or duplicated; tdata held while stalled; s1_axis_tready mirrors m_axis_tready; s0_axis_tready stays 0.
- Drop enable low on beat 2 of 4 with s0 still valid afterwards -> packet finishes with pkt_cnt0=1; no further grant until enable=1, then s0 is granted.
- Preload pkt_cnt1=0xFFFFFFFF via forced state, then complete an s1 packet -> pkt_cnt1=0.
- areset asserted on beat 2 of 4 -> same cycle all outputs reach reset values (tvalid=0, busy=0, counters 0). After release, s1 valid alone is granted, with source 0 priority restored when both valid.
